snake_body_store: RTL

//   Upstream of the VGA snake draw FSM: holds the head direction and the (x,y) of every snake segment.
//   On each `step` pulse from the draw FSM (issued after erase, before redraw) it moves the head one cell and shifts the body.
//   It applies any pending growth, then scans for self-collision; `done` reports completion.
//   The draw FSM indexes segments through a combinational read port while `busy`=0.

---
 rtl/snake_body_store.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - snake segment store: direction, move/shift, growth, wall and self-collision scan
// Optional feature: SNAKE_WRAP_EN (edges wrap around instead of killing the snake).
module snake_body_store #(
    parameter int MAX_LEN  = 8,
    parameter int INIT_LEN = 2,
    parameter int XDIM     = 10,
    parameter int YDIM     = 10,
    parameter int XSCREEN  = 160,
    parameter int YSCREEN  = 120,
    parameter int X0       = 39,
    parameter int Y0       = 59,
    parameter int IW       = 3
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic [3:0]    key_n,
    input  logic          step,
    input  logic          grow,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_x,
    output logic [6:0]    rd_y,
    output logic [IW:0]   length,
    output logic [7:0]    head_x,
    output logic [6:0]    head_y,
    output logic          busy,
    output logic          done,
    output logic          dead
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MOVE  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Direction code equals the key bit index; the opposite direction is the bitwise inverse.
    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_UP    = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    localparam logic [8:0]  XSTEP9 = 9'(XDIM);
    localparam logic [8:0]  XLIM9  = 9'(XSCREEN - XDIM);
    localparam logic [7:0]  XSTEP  = 8'(XDIM);
    localparam logic [7:0]  XLIM   = 8'(XSCREEN - XDIM);
    localparam logic [8:0]  YSTEP9 = 9'(YDIM);
    localparam logic [8:0]  YLIM9  = 9'(YSCREEN - YDIM);
    localparam logic [6:0]  YSTEP  = 7'(YDIM);
    localparam logic [6:0]  YLIM   = 7'(YSCREEN - YDIM);
    localparam logic [IW:0] MAXL   = (IW+1)'(MAX_LEN);

    logic [7:0]    seg_x [MAX_LEN];
    logic [6:0]    seg_y [MAX_LEN];
    logic [1:0]    state;
    logic [1:0]    dir_cur;
    logic [1:0]    dir_req;
    logic          grow_pend;
    logic [IW-1:0] idx;

    logic [3:0] key_ok;
    logic       at_edge;
    logic       wall_hit;
    logic [7:0] next_x;
    logic [6:0] next_y;

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    assign key_ok = ~key_n & ~(4'b0001 << (~dir_cur));

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if ({1'b0, rd_idx} < MAXL) begin
            rd_x = seg_x[rd_idx];
            rd_y = seg_y[rd_idx];
        end
    end

    // Next head position; at_edge selects the wrapped coordinate or flags a wall.
    always_comb begin
        at_edge = 1'b0;
        next_x  = seg_x[0];
        next_y  = seg_y[0];
        case (dir_req)
            D_RIGHT: begin
                at_edge = ({1'b0, seg_x[0]} + XSTEP9) > XLIM9;
                next_x  = at_edge ? 8'd0 : seg_x[0] + XSTEP;
            end
            D_LEFT: begin
                at_edge = {1'b0, seg_x[0]} < XSTEP9;
                next_x  = at_edge ? XLIM : seg_x[0] - XSTEP;
            end
            D_DOWN: begin
                at_edge = ({2'b0, seg_y[0]} + YSTEP9) > YLIM9;
                next_y  = at_edge ? 7'd0 : seg_y[0] + YSTEP;
            end
            default: begin
                at_edge = {2'b0, seg_y[0]} < YSTEP9;
                next_y  = at_edge ? YLIM : seg_y[0] - YSTEP;
            end
        endcase
`ifdef SNAKE_WRAP_EN
        wall_hit = 1'b0;
`else
        wall_hit = at_edge;
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? 8'(X0 - i*XDIM) : 8'd0;
                seg_y[i] <= (i < INIT_LEN) ? 7'(Y0) : 7'd0;
            end
            length    <= (IW+1)'(INIT_LEN);
            dir_cur   <= D_RIGHT;
            dir_req   <= D_RIGHT;
            grow_pend <= 1'b0;
            dead      <= 1'b0;
            idx       <= '0;
            state     <= S_IDLE;
        end else begin
            if (key_ok[0])      dir_req <= D_RIGHT;
            else if (key_ok[1]) dir_req <= D_DOWN;
            else if (key_ok[2]) dir_req <= D_UP;
            else if (key_ok[3]) dir_req <= D_LEFT;

            case (state)
                S_IDLE: if (step && !dead) state <= S_MOVE;
                S_MOVE: begin
                    dir_cur <= dir_req;
                    if (wall_hit) begin
                        dead  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= next_x;
                        seg_y[0] <= next_y;
                        if (grow_pend) begin
                            grow_pend <= 1'b0;
                            if (length < MAXL) length <= length + 1'b1;
                        end
                        idx   <= (IW)'(1);
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ({1'b0, idx} < length && seg_x[0] == seg_x[idx] && seg_y[0] == seg_y[idx]) begin
                        dead  <= 1'b1;
                        state <= S_DONE;
                    end else if ({1'b0, idx} >= length - 1'b1) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A request arriving during MOVE is kept for the following step.
            if (grow && length < MAXL) grow_pend <= 1'b1;
        end
    end

endmodule
